// File: rtl/seq_alu.sv
// seq_alu: handshaked ALU. Single-cycle ADD/SUB/AND/OR/NOR/LSL/LSR/ASR and
// iterative MUL/DIVU/REMU (WIDTH steps each). R and N/Z/C/V are registered
// behind a valid/ready interface.
// Optional feature macro: SEQ_ALU_MULH_EN (fun 11 = MULH, upper product half).
// Ports:
//   clk, rst              clock (rising edge), async active-high reset
//   in_valid / in_ready   request handshake; A, B, fun captured on accept
//   out_valid / out_ready result handshake
//   R, N, Z, C, V         result and flags, held stable while out_valid
module seq_alu #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       fun,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] R,
  output logic             N,
  output logic             Z,
  output logic             C,
  output logic             V
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned CW  = SHW + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] F_ADD  = 4'd0;
  localparam logic [3:0] F_SUB  = 4'd1;
  localparam logic [3:0] F_AND  = 4'd2;
  localparam logic [3:0] F_OR   = 4'd3;
  localparam logic [3:0] F_NOR  = 4'd4;
  localparam logic [3:0] F_LSL  = 4'd5;
  localparam logic [3:0] F_LSR  = 4'd6;
  localparam logic [3:0] F_ASR  = 4'd7;
  localparam logic [3:0] F_MUL  = 4'd8;
  localparam logic [3:0] F_DIVU = 4'd9;
  localparam logic [3:0] F_REMU = 4'd10;
`ifdef SEQ_ALU_MULH_EN
  localparam logic [3:0] F_MULH = 4'd11;
`endif

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       fun_q, fun_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;   // multiplicand or divisor
  logic [WIDTH-1:0] hi_q, hi_d;       // product high half or partial remainder
  logic [WIDTH-1:0] lo_q, lo_d;       // multiplier/product low or dividend/quotient
  logic [WIDTH-1:0] r_q, r_d;
  logic             n_q, n_d, z_q, z_d, c_q, c_d, v_q, v_d;
  logic             in_ready_q, in_ready_d, out_valid_q, out_valid_d;

  // Operation class decode
  logic is_multi_c, is_mul_q_c;
  always_comb begin
    is_multi_c = (fun == F_MUL) || (fun == F_DIVU) || (fun == F_REMU);
    is_mul_q_c = (fun_q == F_MUL);
`ifdef SEQ_ALU_MULH_EN
    is_multi_c = is_multi_c || (fun == F_MULH);
    is_mul_q_c = is_mul_q_c || (fun_q == F_MULH);
`endif
  end

  // Single-cycle ALU on the live inputs
  logic [WIDTH:0]     add_s, sub_s;
  logic [SHW-1:0]     sh;
  logic [WIDTH-1:0]   alu_r;
  logic               alu_c, alu_v;
  always_comb begin
    add_s = {1'b0, A} + {1'b0, B};
    sub_s = {1'b0, A} - {1'b0, B};
    sh    = B[SHW-1:0];
    alu_r = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (fun)
      F_ADD: begin
        alu_r = add_s[WIDTH-1:0];
        alu_c = add_s[WIDTH];
        alu_v = (A[WIDTH-1] == B[WIDTH-1]) && (add_s[WIDTH-1] != A[WIDTH-1]);
      end
      F_SUB: begin
        alu_r = sub_s[WIDTH-1:0];
        alu_c = sub_s[WIDTH];
        alu_v = (A[WIDTH-1] != B[WIDTH-1]) && (sub_s[WIDTH-1] != A[WIDTH-1]);
      end
      F_AND:   alu_r = A & B;
      F_OR:    alu_r = A | B;
      F_NOR:   alu_r = ~(A | B);
      F_LSL:   alu_r = A << sh;
      F_LSR:   alu_r = A >> sh;
      F_ASR:   alu_r = $unsigned($signed(A) >>> sh);
      default: alu_v = 1'b1;  // illegal: R=0, V=1
    endcase
  end

  // One shift-add multiply step and one restoring-division step
  logic [WIDTH:0]   mul_sum, div_trial, div_diff;
  logic [WIDTH-1:0] mul_hi_nx, mul_lo_nx, div_rem_nx, div_quo_nx;
  logic             div_ok;
  always_comb begin
    mul_sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    mul_hi_nx  = mul_sum[WIDTH:1];
    mul_lo_nx  = {mul_sum[0], lo_q[WIDTH-1:1]};
    div_trial  = {hi_q, lo_q[WIDTH-1]};
    div_diff   = div_trial - {1'b0, opnd_q};
    div_ok     = ~div_diff[WIDTH];
    div_rem_nx = div_ok ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0];
    div_quo_nx = {lo_q[WIDTH-2:0], div_ok};
  end

  // Next-state and output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fun_d   = fun_q;
    opnd_d  = opnd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    r_d     = r_q;
    n_d     = n_q;
    z_d     = z_q;
    c_d     = c_q;
    v_d     = v_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          fun_d = fun;
          if (is_multi_c) begin
            hi_d    = '0;
            lo_d    = (fun == F_MUL || fun == 4'd11) ? B : A;
            opnd_d  = (fun == F_MUL || fun == 4'd11) ? A : B;
            cnt_d   = CW'(WIDTH);
            state_d = S_BUSY;
          end else begin
            r_d     = alu_r;
            c_d     = alu_c;
            v_d     = alu_v;
            state_d = S_DONE;
          end
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (is_mul_q_c) begin
          hi_d = mul_hi_nx;
          lo_d = mul_lo_nx;
        end else begin
          hi_d = div_rem_nx;
          lo_d = div_quo_nx;
        end
        // Last step: result is taken from this step's outputs
        if (cnt_q == CW'(1)) begin
          state_d = S_DONE;
          if (is_mul_q_c) begin
            r_d = mul_lo_nx;
`ifdef SEQ_ALU_MULH_EN
            if (fun_q == F_MULH) r_d = mul_hi_nx;
`endif
            c_d = |mul_hi_nx;
            v_d = |mul_hi_nx;
          end else begin
            r_d = (fun_q == F_REMU) ? div_rem_nx : div_quo_nx;
            c_d = 1'b0;
            v_d = (opnd_q == '0);
          end
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_q != S_DONE && state_d == S_DONE) begin
      n_d = r_d[WIDTH-1];
      z_d = (r_d == '0);
    end
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      fun_q       <= '0;
      opnd_q      <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      r_q         <= '0;
      n_q         <= 1'b0;
      z_q         <= 1'b0;
      c_q         <= 1'b0;
      v_q         <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fun_q       <= fun_d;
      opnd_q      <= opnd_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      r_q         <= r_d;
      n_q         <= n_d;
      z_q         <= z_d;
      c_q         <= c_d;
      v_q         <= v_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign R         = r_q;
  assign N         = n_q;
  assign Z         = z_q;
  assign C         = c_q;
  assign V         = v_q;

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed testbench for seq_alu with an arithmetic reference
// model, a per-cycle output compare process and literal expectations.
module tb_seq_alu;

  localparam int unsigned W = 16;

  typedef struct packed {
    logic [W-1:0] r;
    logic         n;
    logic         z;
    logic         c;
    logic         v;
  } res_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] A, B, R;
  logic [3:0]   fun;
  logic         N, Z, C, V;

  int   tests = 0;
  int   fails = 0;
  res_t exp_res = '0;

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .fun(fun), .out_valid(out_valid), .out_ready(out_ready),
    .R(R), .N(N), .Z(Z), .C(C), .V(V)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic mulh_enabled();
`ifdef SEQ_ALU_MULH_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Reference model from plain arithmetic
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] f);
    res_t   res;
    longint ua, ub, p;
    int     sa, sb, s;
    int     shamt;
    logic signed [W-1:0] sr;
    ua = longint'(a);
    ub = longint'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    shamt = int'(b) % W;
    res = '0;
    case (f)
      4'd0: begin
        res.r = W'(ua + ub);
        res.c = (ua + ub) >= (longint'(1) << W);
        s = sa + sb;
        res.v = (s > (2**(W-1) - 1)) || (s < -(2**(W-1)));
      end
      4'd1: begin
        res.r = W'(ua - ub);
        res.c = (ua < ub);
        s = sa - sb;
        res.v = (s > (2**(W-1) - 1)) || (s < -(2**(W-1)));
      end
      4'd2: res.r = a & b;
      4'd3: res.r = a | b;
      4'd4: res.r = ~(a | b);
      4'd5: res.r = W'(ua << shamt);
      4'd6: res.r = W'(ua >> shamt);
      4'd7: begin sr = $signed(a); sr = sr >>> shamt; res.r = sr; end
      4'd8: begin
        p = ua * ub;
        res.r = W'(p);
        res.c = (p >> W) != 0;
        res.v = res.c;
      end
      4'd9:  begin res.r = (b == 0) ? '1 : W'(ua / ub); res.v = (b == 0); end
      4'd10: begin res.r = (b == 0) ? a  : W'(ua % ub); res.v = (b == 0); end
      default: begin
        if (f == 4'd11 && mulh_enabled()) begin
          p = ua * ub;
          res.r = W'(p >> W);
          res.c = (p >> W) != 0;
          res.v = res.c;
        end else begin
          res.v = 1'b1;
        end
      end
    endcase
    res.n = res.r[W-1];
    res.z = (res.r == 0);
    return res;
  endfunction

  function automatic int model_lat(input logic [3:0] f);
    if (f == 4'd8 || f == 4'd9 || f == 4'd10 || (f == 4'd11 && mulh_enabled()))
      return W + 1;
    return 1;
  endfunction

  // Per-cycle compare of the delivered result against the model
  always @(negedge clk) begin
    if (!rst && out_valid)
      chk("out_result", {R, N, Z, C, V}, exp_res);
  end

  // Wait for out_valid after an accept edge, measuring latency in cycles
  task automatic wait_result(input string name, input int exp_lat);
    int lat;
    lat = 1;
    while (!out_valid && lat < 200) begin
      chk({name, "_in_ready_busy"}, in_ready, 1'b0);
      @(posedge clk); #1;
      lat++;
    end
    chk({name, "_out_valid"}, out_valid, 1'b1);
    chk({name, "_latency"}, lat, exp_lat);
  endtask

  task automatic issue(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [3:0] f);
    chk({name, "_in_ready_idle"}, in_ready, 1'b1);
    exp_res  = model(a, b, f);
    A        = a;
    B        = b;
    fun      = f;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_result(name, model_lat(f));
  endtask

  task automatic release_result(input string name);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({name, "_release"}, {out_valid, in_ready}, 2'b01);
  endtask

  task automatic op_lit(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [3:0] f, input res_t lit);
    issue(name, a, b, f);
    chk({name, "_literal"}, {R, N, Z, C, V}, lit);
    release_result(name);
  endtask

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   f;
  } vec_t;

  vec_t vecs[12];
  res_t lit11;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; fun = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {in_ready, out_valid, R, N, Z, C, V}, {2'b10, 20'h0});
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_after_reset", {in_ready, out_valid}, 2'b10);

    op_lit("add_ovf",  16'h7FFF, 16'h0001, 4'd0,  {16'h8000, 4'b1001});
    op_lit("sub_brw",  16'h0000, 16'h0001, 4'd1,  {16'hFFFF, 4'b1010});
    op_lit("asr",      16'h8000, 16'h0013, 4'd7,  {16'hF000, 4'b1000});
    op_lit("mul",      16'h0100, 16'h0100, 4'd8,  {16'h0000, 4'b0111});
    lit11 = mulh_enabled() ? res_t'({16'h0001, 4'b0011}) : res_t'({16'h0000, 4'b0101});
    op_lit("fun11",    16'h0100, 16'h0100, 4'd11, lit11);
    op_lit("divu",     16'd100,  16'd7,    4'd9,  {16'd14, 4'b0000});
    op_lit("remu",     16'd100,  16'd7,    4'd10, {16'd2,  4'b0000});
    op_lit("divu_z",   16'h1234, 16'h0000, 4'd9,  {16'hFFFF, 4'b1001});
    op_lit("remu_z",   16'h1234, 16'h0000, 4'd10, {16'h1234, 4'b0001});
    op_lit("illegal",  16'h1234, 16'h5678, 4'd13, {16'h0000, 4'b0101});

    // Model-checked vectors covering remaining ops and edge cases
    vecs[0]  = '{16'hFFFF, 16'h0001, 4'd0};
    vecs[1]  = '{16'h8000, 16'h0001, 4'd1};
    vecs[2]  = '{16'hF0F0, 16'h3C3C, 4'd2};
    vecs[3]  = '{16'hF0F0, 16'h0F0F, 4'd3};
    vecs[4]  = '{16'hF0F0, 16'h0F0F, 4'd4};
    vecs[5]  = '{16'h0001, 16'h001F, 4'd5};
    vecs[6]  = '{16'h8001, 16'h0004, 4'd6};
    vecs[7]  = '{16'hFFFF, 16'hFFFF, 4'd8};
    vecs[8]  = '{16'hFFFF, 16'h0001, 4'd9};
    vecs[9]  = '{16'hABCD, 16'h0100, 4'd10};
    vecs[10] = '{16'h0005, 16'h1234, 4'd9};
    vecs[11] = '{16'h0000, 16'h0000, 4'd15};
    for (int i = 0; i < 12; i++) begin
      issue($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].f);
      release_result($sformatf("vec%0d", i));
    end

    // Backpressure: result held, new request ignored until after handshake
    issue("bp", 16'd3, 16'd4, 4'd0);
    chk("bp_literal", R, 16'd7);
    A = 16'd9; B = 16'd9; fun = 4'd0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_hold", {out_valid, in_ready, R}, {2'b10, 16'd7});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_release", {out_valid, in_ready}, 2'b01);
    exp_res = model(16'd9, 16'd9, 4'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_result("bp_next", 1);
    chk("bp_next_literal", R, 16'h0012);
    release_result("bp_next");

    // Asynchronous reset in the middle of a multiply
    exp_res = model(16'h0100, 16'h0100, 4'd8);
    A = 16'h0100; B = 16'h0100; fun = 4'd8; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("rst_mid_mul", {in_ready, out_valid, R, N, Z, C, V}, {2'b10, 20'h0});
    @(posedge clk); #1;
    rst = 1'b0;
    op_lit("add_after_rst", 16'd1, 16'd1, 4'd0, {16'd2, 4'b0000});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
